fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding I$ request, two-slot packets to decode.
// Optional IF_PERF_CNT_EN adds saturating packet and stall counters.
module fetch_ctrl #(
    parameter int unsigned       ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] INIT_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              ic_req_valid_o,
    input  logic              ic_req_ready_i,
    output logic [ADDR_W-1:0] ic_req_addr_o,
    input  logic              ic_resp_valid_i,
    input  logic [63:0]       ic_resp_data_i,
    input  logic              ic_resp_err_i,
    output logic [1:0]        out_valid_o,
    output logic [31:0]       out_inst_0_o,
    output logic [31:0]       out_inst_1_o,
    output logic [ADDR_W-1:0] out_addr_0_o,
    output logic [ADDR_W-1:0] out_addr_1_o,
    output logic              out_exc_o,
    input  logic              out_ready_i
`ifdef IF_PERF_CNT_EN
   ,output logic [31:0]       perf_pkt_cnt_o,
    output logic [31:0]       perf_stall_cnt_o
`endif
);
    localparam int unsigned PKT_BYTES = 8;
    localparam logic [ADDR_W-1:0] PKT_INC  = ADDR_W'(PKT_BYTES);
    localparam logic [ADDR_W-1:0] SLOT_INC = ADDR_W'(4);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_KILL  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        ov_q, ov_d;
    logic              exc_q, exc_d;
    logic [31:0]       inst0_q, inst0_d, inst1_q, inst1_d;
    logic [ADDR_W-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [ADDR_W-1:0] base;
    logic              outstanding;
    logic              unused_lsb;

    assign base       = {pc_q[ADDR_W-1:3], 3'b000};
    assign unused_lsb = ^{redirect_pc_i[1:0], pc_q[1:0]};

    // A redirect must still swallow the in-flight response if one is owed.
    assign outstanding = (state_q == S_WAIT && !ic_resp_valid_i) ||
                         (state_q == S_REQ  &&  ic_req_ready_i)  ||
                         (state_q == S_KILL && !ic_resp_valid_i);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ov_d    = ov_q;
        exc_d   = exc_q;
        inst0_d = inst0_q;
        inst1_d = inst1_q;
        addr0_d = addr0_q;
        addr1_d = addr1_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  if (ic_req_ready_i) state_d = S_WAIT;
            S_WAIT: if (ic_resp_valid_i) begin
                inst0_d = ic_resp_data_i[31:0];
                inst1_d = ic_resp_data_i[63:32];
                addr0_d = base;
                addr1_d = base + SLOT_INC;
                if (ic_resp_err_i) begin
                    state_d = S_FAULT;
                    exc_d   = 1'b1;
                    ov_d    = pc_q[2] ? 2'b10 : 2'b01;
                end else begin
                    state_d = S_HOLD;
                    ov_d    = pc_q[2] ? 2'b10 : 2'b11;
                    pc_d    = base + PKT_INC;
                end
            end
            S_HOLD: if (out_ready_i) begin
                state_d = S_REQ;
                ov_d    = 2'b00;
            end
            S_FAULT: if (out_ready_i) begin
                ov_d  = 2'b00;
                exc_d = 1'b0;
            end
            S_KILL: if (ic_resp_valid_i) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
        if (redirect_valid_i) begin
            pc_d    = {redirect_pc_i[ADDR_W-1:2], 2'b00};
            ov_d    = 2'b00;
            exc_d   = 1'b0;
            state_d = outstanding ? S_KILL : S_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= INIT_PC;
            ov_q    <= 2'b00;
            exc_q   <= 1'b0;
            inst0_q <= '0;
            inst1_q <= '0;
            addr0_q <= '0;
            addr1_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ov_q    <= ov_d;
            exc_q   <= exc_d;
            inst0_q <= inst0_d;
            inst1_q <= inst1_d;
            addr0_q <= addr0_d;
            addr1_q <= addr1_d;
        end
    end

    assign ic_req_valid_o = (state_q == S_REQ);
    assign ic_req_addr_o  = ic_req_valid_o ? base : '0;
    assign out_valid_o    = ov_q;
    assign out_exc_o      = exc_q;
    assign out_inst_0_o   = inst0_q;
    assign out_inst_1_o   = inst1_q;
    assign out_addr_0_o   = addr0_q;
    assign out_addr_1_o   = addr1_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] pkt_q, stall_q;
    logic        pkt_inc, stall_inc;

    assign pkt_inc   = (ov_q != 2'b00) && out_ready_i;
    assign stall_inc = (state_q == S_REQ  && !ic_req_ready_i) ||
                       (state_q == S_HOLD && !out_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q   <= '0;
            stall_q <= '0;
        end else begin
            if (pkt_inc && pkt_q != '1)     pkt_q   <= pkt_q + 32'd1;
            if (stall_inc && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_pkt_cnt_o   = pkt_q;
    assign perf_stall_cnt_o = stall_q;
`endif

endmodule
